// File: rtl/dmem_bank.sv
// Simple dual-port, byte-addressed data memory with per-byte write enables,
// write-first forwarding and an optional clear sweep; `DMEM_OUTREG_EN adds a second read stage.
module dmem_bank #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    WRITE_EN,
  input  logic [ADDR_WIDTH-1:0]   W_ADDR,
  input  logic [DATA_WIDTH-1:0]   DIN,
  input  logic [DATA_WIDTH/8-1:0] W_BE,
  input  logic                    READ_EN,
  input  logic [ADDR_WIDTH-1:0]   R_ADDR,
  output logic [DATA_WIDTH-1:0]   DOUT,
  output logic                    DOUT_VALID,
  output logic                    BUSY
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int LB    = (NB > 1) ? $clog2(NB) : 0;
  localparam int WW    = ADDR_WIDTH - LB;
  localparam int DEPTH = 2 ** WW;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WW-1:0]         r_ptr;
  logic [WW-1:0]         w_ptr_nxt;
  logic [NB-1:0][7:0]    r_mem [DEPTH];
  logic [NB-1:0][7:0]    w_din;
  logic [NB-1:0][7:0]    w_fwd;
  logic [WW-1:0]         w_widx;
  logic [WW-1:0]         w_ridx;
  logic                  w_run;
  logic                  w_wr;
  logic                  w_clr;
  logic                  w_rd;
  logic [DATA_WIDTH-1:0] r_dout1;
  logic                  r_vld1;

  assign w_din  = DIN;
  assign w_widx = W_ADDR[ADDR_WIDTH-1:LB];
  assign w_ridx = R_ADDR[ADDR_WIDTH-1:LB];
  assign w_run  = (r_state == ST_RUN);
  assign w_wr   = RST_N && w_run && WRITE_EN;
  assign w_clr  = RST_N && (r_state == ST_CLEAR);
  assign w_rd   = w_run && READ_EN;
  assign BUSY   = (r_state == ST_CLEAR);

  generate
    if (LB > 0) begin : g_lsb
      logic w_unused_lsb;
      assign w_unused_lsb = ^{W_ADDR[LB-1:0], R_ADDR[LB-1:0]};
    end
  endgenerate

  // State and clear-pointer registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= RST_STATE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Next-state logic: sweep one word per cycle, then run until reset
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_CLEAR: begin
        w_ptr_nxt = r_ptr + {{(WW-1){1'b0}}, 1'b1};
        if (r_ptr == WW'(DEPTH - 1)) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_RUN: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  // Storage array; reset never touches contents, only the sweep does
  always_ff @(posedge CLK) begin
    if (w_clr) begin
      r_mem[r_ptr] <= '0;
    end else if (w_wr) begin
      for (int k = 0; k < NB; k++) begin
        if (W_BE[k]) begin
          r_mem[w_widx][k] <= w_din[k];
        end
      end
    end
  end

  // Write-first merge for a read hitting the word being written this cycle
  always_comb begin
    w_fwd = r_mem[w_ridx];
    for (int k = 0; k < NB; k++) begin
      if (WRITE_EN && (w_widx == w_ridx) && W_BE[k]) begin
        w_fwd[k] = w_din[k];
      end else begin
        w_fwd[k] = r_mem[w_ridx][k];
      end
    end
  end

  // First read stage: captures forwarded data, holds when idle
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_dout1 <= '0;
      r_vld1  <= 1'b0;
    end else begin
      r_vld1 <= w_rd;
      if (w_rd) begin
        r_dout1 <= w_fwd;
      end
    end
  end

`ifdef DMEM_OUTREG_EN
  logic [DATA_WIDTH-1:0] r_dout2;
  logic                  r_vld2;

  // Second read stage for timing relief; loads only behind a valid stage-1 word
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_dout2 <= '0;
      r_vld2  <= 1'b0;
    end else begin
      r_vld2 <= r_vld1;
      if (r_vld1) begin
        r_dout2 <= r_dout1;
      end
    end
  end

  assign DOUT       = r_dout2;
  assign DOUT_VALID = r_vld2;
`else
  assign DOUT       = r_dout1;
  assign DOUT_VALID = r_vld1;
`endif

endmodule

// File: tb/tb_dmem_bank.sv
// Directed self-checking bench for dmem_bank (16-word configuration).
module tb_dmem_bank;

`ifdef DMEM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        CLK;
  logic        RST_N;
  logic        WRITE_EN;
  logic [5:0]  W_ADDR;
  logic [31:0] DIN;
  logic [3:0]  W_BE;
  logic        READ_EN;
  logic [5:0]  R_ADDR;
  logic [31:0] DOUT;
  logic        DOUT_VALID;
  logic        BUSY;

  int vectors = 0;
  int errors  = 0;
  int edges;

  dmem_bank #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .CLEAR_ON_RESET(1)) dut (
    .CLK(CLK), .RST_N(RST_N), .WRITE_EN(WRITE_EN), .W_ADDR(W_ADDR), .DIN(DIN),
    .W_BE(W_BE), .READ_EN(READ_EN), .R_ADDR(R_ADDR), .DOUT(DOUT),
    .DOUT_VALID(DOUT_VALID), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
    WRITE_EN = 1'b1; W_ADDR = a; DIN = d; W_BE = be;
    step();
    WRITE_EN = 1'b0; W_BE = 4'h0;
  endtask

  task automatic rd(input string tag, input logic [5:0] a, input logic [31:0] exp);
    READ_EN = 1'b1; R_ADDR = a;
    step();
    READ_EN = 1'b0;
    for (int i = 1; i < LAT; i++) step();
    chk({tag, "_data"}, DOUT, exp);
    chk({tag, "_valid"}, {31'd0, DOUT_VALID}, 32'd1);
  endtask

  task automatic wait_sweep(input int start);
    edges = start;
    while (BUSY && edges < 40) begin
      step();
      edges++;
    end
  endtask

  initial begin
    RST_N = 1'b0; WRITE_EN = 1'b0; W_ADDR = 6'd0; DIN = 32'd0; W_BE = 4'h0;
    READ_EN = 1'b0; R_ADDR = 6'd0;
    step();
    chk("rst_dout", DOUT, 32'd0);
    chk("rst_valid", {31'd0, DOUT_VALID}, 32'd0);
    chk("rst_busy", {31'd0, BUSY}, 32'd1);
    RST_N = 1'b1;
    wait_sweep(0);
    chk("sweep1_len", 32'(edges), 32'd16);

    // preload word 5, then a fresh reset must wipe it
    wr(6'h14, 32'hDEADBEEF, 4'hF);
    rd("preload", 6'h14, 32'hDEADBEEF);
    RST_N = 1'b0;
    step();
    chk("rst2_busy", {31'd0, BUSY}, 32'd1);
    RST_N = 1'b1;
    wait_sweep(0);
    chk("sweep2_len", 32'(edges), 32'd16);
    rd("cleared_w5", 6'h14, 32'h00000000);

    // byte-enable merge, low address bits ignored
    wr(6'h08, 32'hAABBCCDD, 4'hF);
    wr(6'h08, 32'h11223344, 4'h5);
    rd("be_merge", 6'h0A, 32'hAA22CC44);
    wr(6'h08, 32'h99999999, 4'h0);
    rd("be_none", 6'h09, 32'hAA22CC44);

    // write-first forwarding on same word
    wr(6'h0C, 32'h12345678, 4'hF);
    WRITE_EN = 1'b1; W_ADDR = 6'h0C; DIN = 32'hFFFFFFFF; W_BE = 4'h8;
    rd("fwd", 6'h0C, 32'hFF345678);
    WRITE_EN = 1'b0; W_BE = 4'h0;
    rd("fwd_again", 6'h0C, 32'hFF345678);

    // different-word read during write returns stored data
    WRITE_EN = 1'b1; W_ADDR = 6'h10; DIN = 32'h0BADF00D; W_BE = 4'hF;
    rd("rdw_diff", 6'h08, 32'hAA22CC44);
    WRITE_EN = 1'b0; W_BE = 4'h0;
    rd("rdw_diff_wr", 6'h10, 32'h0BADF00D);

    // hold: DOUT keeps value, valid drops
    wr(6'h04, 32'h5A5AA5A5, 4'hF);
    rd("hold_rd", 6'h04, 32'h5A5AA5A5);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_data", DOUT, 32'h5A5AA5A5);
      chk("hold_valid", {31'd0, DOUT_VALID}, 32'd0);
    end

    // reset on sweep cycle 4, then requests during the restarted sweep
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("mid_busy", {31'd0, BUSY}, 32'd1);
    RST_N = 1'b0;
    step();
    chk("mid_rst_busy", {31'd0, BUSY}, 32'd1);
    RST_N = 1'b1;
    step();
    step();
    WRITE_EN = 1'b1; W_ADDR = 6'h00; DIN = 32'hCAFEF00D; W_BE = 4'hF;
    READ_EN = 1'b1; R_ADDR = 6'h14;
    step();
    WRITE_EN = 1'b0; READ_EN = 1'b0; W_BE = 4'h0;
    chk("busy_valid", {31'd0, DOUT_VALID}, 32'd0);
    chk("busy_dout", DOUT, 32'd0);
    wait_sweep(3);
    chk("sweep3_len", 32'(edges), 32'd16);
    rd("busy_wr_dropped", 6'h00, 32'h00000000);
    rd("post_clear_w1", 6'h04, 32'h00000000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/dmem_bank.md
Name: dmem_bank

Overview:
Parametrised successor to the byte-wide data BRAM. It provides a simple dual-port, byte-addressed, word-wide data memory with per-byte write enables and write-first read-during-write forwarding. An optional reset-time clear sweep is driven by a small state machine. It sits in the MEM stage of the pipelined core, where load/store units issue one read and one write per cycle.

Parameters:
ADDR_WIDTH, 10, byte-address width; memory size is 2**ADDR_WIDTH bytes.
DATA_WIDTH, 32, word width in bits; must be a multiple of 8 and ≥8. NB = DATA_WIDTH/8 byte lanes; DEPTH = 2**ADDR_WIDTH/NB words.
CLEAR_ON_RESET, 1, 1 = zero all words after reset before accepting requests; 0 = no sweep.

Ports:
CLK  input  1  clock; all logic on posedge.
RST_N  input  1  reset, synchronous, active-low.
WRITE_EN  input  1  write request.
W_ADDR  input  ADDR_WIDTH  byte write address; low log2(NB) bits ignored.
DIN  input  DATA_WIDTH  write data, lane k = DIN[8k+7:8k].
W_BE  input  NB  byte-lane write enables.
READ_EN  input  1  read request.
R_ADDR  input  ADDR_WIDTH  byte read address; low log2(NB) bits ignored.
DOUT  output  DATA_WIDTH  registered read data.
DOUT_VALID  output  1  one-cycle pulse when DOUT carries new read data.
BUSY  output  1  high while clear sweep runs; requests ignored.

Behaviour:
- One clock domain, CLK. Reset is synchronous and active-low on RST_N: sampled at posedge CLK.
- Word index = ADDR[ADDR_WIDTH-1:log2(NB)]. No misalignment detection; low bits are dropped.
- Reset (RST_N=0 at edge) sets:
  - DOUT=0, DOUT_VALID=0.
  - Clear pointer=0.
  - State=CLEAR if CLEAR_ON_RESET=1, else RUN.
  - BUSY output reflects state: 1 in CLEAR, 0 in RUN.
  - Memory contents are untouched by reset itself.
- FSM states:
  - CLEAR: each cycle writes all-zero to word[ptr], ptr++. After the write to word DEPTH-1, next state is RUN. The sweep takes exactly DEPTH cycles. WRITE_EN/READ_EN are ignored: no write, no DOUT change, DOUT_VALID=0.
  - RUN: normal operation; stays in RUN until reset.
- Reset mid-sweep: ptr returns to 0 and the sweep restarts from word 0 (full DEPTH cycles again).
- Write (RUN, WRITE_EN=1): on the edge, lanes with W_BE[k]=1 update; other lanes keep their old value. W_BE=0 → no change.
- Read (RUN, READ_EN=1): latency 1. At edge N, DOUT ← word[R_ADDR] and DOUT_VALID=1 during cycle N+1.
- READ_EN=0: DOUT holds its previous value and DOUT_VALID=0.
- Read-during-write, same word index: write-first. DOUT lane k = DIN lane k if W_BE[k]=1, else the old stored lane.
- Read-during-write, different word: independent; the read returns the stored contents.
- No back-pressure: every request in RUN completes.

Optional Feature:
DMEM_OUTREG_EN
- Defined: adds a second output register stage. Read latency becomes 2, and DOUT_VALID is delayed by the same 2 cycles to stay aligned with DOUT. Both stages reset to 0. The stage-2 register loads only when stage-1 valid=1, else it holds.
- Forwarding is resolved in stage 1, so results are identical to the undefined case, just one cycle later.
- Undefined: single register, latency 1 as above.

Test Plan:
All tests use ADDR_WIDTH=6, DATA_WIDTH=32 (16 words).
- Preload word 5 = 0xDEADBEEF; RST_N=0 for 1 edge, then release → BUSY=1 for exactly 16 cycles then 0; read 0x14 → DOUT=0x00000000, DOUT_VALID=1 one cycle later.
- After sweep: write 0x08, DIN=0xAABBCCDD, W_BE=4'b1111, then write 0x08, DIN=0x11223344, W_BE=4'b0101 → read 0x0A returns 0xAA22CC44 (low addr bits ignored).
- Word 3 = 0x12345678; same cycle write 0x0C, DIN=0xFFFFFFFF, W_BE=4'b1000 and read 0x0C → DOUT=0xFF345678 next cycle; subsequent read gives the same value.
- During sweep cycle 4: assert RST_N=0 → BUSY stays 1 and the sweep restarts, ending 16 cycles after release. A WRITE_EN during BUSY leaves memory unchanged (read back 0).
- Read 0x04 → DOUT valid; hold READ_EN=0 for 3 cycles → DOUT unchanged, DOUT_VALID=0.
- With DMEM_OUTREG_EN defined, repeat the forwarding test → 0xFF345678 appears with DOUT_VALID=1 two cycles after the request.
